flash_phy_rd_sched: RTL and testbench



---
 rtl/flash_phy_rd_sched.sv | 179 +++++++++++++++++
 tb/tb_flash_phy_rd_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_phy_rd_sched.sv
// Multi-bank flash read scheduler: issues host reads to banks under per-bank credits,
// buffers each bank's responses and returns them to the host strictly in request order.
module flash_phy_rd_sched #(
  parameter int unsigned NumBanks     = 2,
  parameter int unsigned PagesPerBank = 256,
  parameter int unsigned WordsPerPage = 256,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned OutPerBank   = 2,
  localparam int unsigned PageW    = $clog2(PagesPerBank),
  localparam int unsigned WordW    = $clog2(WordsPerPage),
  localparam int unsigned BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1,
  localparam int unsigned AddrW    = BankW + PageW + WordW,
  localparam int unsigned SeqDepth = NumBanks * OutPerBank
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          host_req_i,
  input  logic [AddrW-1:0]              host_addr_i,
  output logic                          host_req_rdy_o,
  output logic                          host_req_done_o,
  output logic [DataWidth-1:0]          host_rdata_o,
  output logic                          host_rerr_o,
  output logic [NumBanks-1:0]           bank_req_o,
  output logic [PageW+WordW-1:0]        bank_addr_o,
  input  logic [NumBanks-1:0]           bank_rdy_i,
  input  logic [NumBanks-1:0]           bank_done_i,
  input  logic [NumBanks*DataWidth-1:0] bank_rdata_i,
  output logic                          idle_o,
  output logic                          proto_err_o
);

  localparam int unsigned InW     = PageW + WordW;
  localparam int unsigned CredW   = $clog2(OutPerBank + 1);
  localparam int unsigned RspPtrW = (OutPerBank > 1) ? $clog2(OutPerBank) : 1;
  localparam int unsigned SeqPtrW = (SeqDepth > 1) ? $clog2(SeqDepth) : 1;
  localparam int unsigned SeqCntW = $clog2(SeqDepth + 1);
  localparam logic [BankW:0] NumBanksW = (BankW + 1)'(NumBanks);

  typedef struct packed {
    logic             err;
    logic [BankW-1:0] bank;
  } seq_entry_t;

  seq_entry_t           r_seq_mem [SeqDepth];
  logic [SeqPtrW-1:0]   r_seq_wr;
  logic [SeqPtrW-1:0]   r_seq_rd;
  logic [SeqCntW-1:0]   r_seq_cnt;
  logic [DataWidth-1:0] r_rsp_mem [NumBanks][OutPerBank];
  logic [RspPtrW-1:0]   r_rsp_wr  [NumBanks];
  logic [RspPtrW-1:0]   r_rsp_rd  [NumBanks];
  logic [CredW-1:0]     r_rsp_cnt [NumBanks];
  logic [CredW-1:0]     r_credit  [NumBanks];
  logic                 r_proto_err;

  logic [BankW-1:0]    w_bank;
  logic [BankW-1:0]    w_bank_idx;
  logic                w_good;
  logic                w_seq_full;
  logic                w_seq_empty;
  logic                w_rdy;
  logic                w_issue;
  logic                w_done;
  seq_entry_t          w_head;
  seq_entry_t          w_entry;
  logic [NumBanks-1:0] w_rsp_push;
  logic [NumBanks-1:0] w_rsp_pop;
  logic [NumBanks-1:0] w_cred_inc;

  // Out-of-range bank fields are steered to bank 0 so no array is indexed past its end
  assign w_bank      = host_addr_i[InW +: BankW];
  assign w_good      = {1'b0, w_bank} < NumBanksW;
  assign w_bank_idx  = w_good ? w_bank : '0;
  assign w_seq_full  = (r_seq_cnt == SeqCntW'(SeqDepth));
  assign w_seq_empty = (r_seq_cnt == '0);
  assign w_rdy       = !w_seq_full &&
                       (!w_good || (bank_rdy_i[w_bank_idx] &&
                                    (r_credit[w_bank_idx] < CredW'(OutPerBank))));
  assign w_issue     = host_req_i && w_rdy;
  assign w_head      = r_seq_mem[r_seq_rd];
  assign w_entry.err  = !w_good;
  assign w_entry.bank = w_bank_idx;

  assign host_req_rdy_o  = w_rdy;
  assign host_req_done_o = w_done;
  assign bank_addr_o     = host_addr_i[InW-1:0];
  assign idle_o          = w_seq_empty;
  assign proto_err_o     = r_proto_err;

  // In-order completion from the sequence head
  always_comb begin
    w_done       = 1'b0;
    host_rdata_o = '0;
    host_rerr_o  = 1'b0;
    if (!w_seq_empty) begin
      if (w_head.err) begin
        w_done      = 1'b1;
        host_rerr_o = 1'b1;
      end else if (r_rsp_cnt[w_head.bank] != '0) begin
        w_done       = 1'b1;
        host_rdata_o = r_rsp_mem[w_head.bank][r_rsp_rd[w_head.bank]];
      end
    end
  end

  // Per-bank strobes: response accept, response pop, credit take
  always_comb begin
    w_rsp_push = '0;
    w_rsp_pop  = '0;
    w_cred_inc = '0;
    for (int b = 0; b < NumBanks; b++) begin
      w_rsp_push[b] = bank_done_i[b] && (r_credit[b] > r_rsp_cnt[b]);
      w_rsp_pop[b]  = w_done && !w_head.err && (w_head.bank == BankW'(b));
      w_cred_inc[b] = w_issue && w_good && (w_bank == BankW'(b));
    end
    bank_req_o = w_cred_inc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_seq_wr    <= '0;
      r_seq_rd    <= '0;
      r_seq_cnt   <= '0;
      r_proto_err <= 1'b0;
      for (int b = 0; b < NumBanks; b++) begin
        r_rsp_wr[b]  <= '0;
        r_rsp_rd[b]  <= '0;
        r_rsp_cnt[b] <= '0;
        r_credit[b]  <= '0;
      end
    end else begin
      if (w_issue) begin
        r_seq_wr <= (r_seq_wr == SeqPtrW'(SeqDepth - 1)) ? '0 : r_seq_wr + SeqPtrW'(1);
      end
      if (w_done) begin
        r_seq_rd <= (r_seq_rd == SeqPtrW'(SeqDepth - 1)) ? '0 : r_seq_rd + SeqPtrW'(1);
      end
      if (w_issue && !w_done) begin
        r_seq_cnt <= r_seq_cnt + SeqCntW'(1);
      end else if (!w_issue && w_done) begin
        r_seq_cnt <= r_seq_cnt - SeqCntW'(1);
      end
      // Any bank completion without a matching outstanding credit is a straggler
      if ((bank_done_i & ~w_rsp_push) != '0) begin
        r_proto_err <= 1'b1;
      end
      for (int b = 0; b < NumBanks; b++) begin
        if (w_rsp_push[b]) begin
          r_rsp_wr[b] <= (r_rsp_wr[b] == RspPtrW'(OutPerBank - 1)) ? '0 : r_rsp_wr[b] + RspPtrW'(1);
        end
        if (w_rsp_pop[b]) begin
          r_rsp_rd[b] <= (r_rsp_rd[b] == RspPtrW'(OutPerBank - 1)) ? '0 : r_rsp_rd[b] + RspPtrW'(1);
        end
        if (w_rsp_push[b] && !w_rsp_pop[b]) begin
          r_rsp_cnt[b] <= r_rsp_cnt[b] + CredW'(1);
        end else if (!w_rsp_push[b] && w_rsp_pop[b]) begin
          r_rsp_cnt[b] <= r_rsp_cnt[b] - CredW'(1);
        end
        if (w_cred_inc[b] && !w_rsp_pop[b]) begin
          r_credit[b] <= r_credit[b] + CredW'(1);
        end else if (!w_cred_inc[b] && w_rsp_pop[b]) begin
          r_credit[b] <= r_credit[b] - CredW'(1);
        end
      end
    end
  end

  // Storage arrays carry no reset; occupancy counters qualify every read
  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_seq_mem[r_seq_wr] <= w_entry;
    end
    for (int b = 0; b < NumBanks; b++) begin
      if (w_rsp_push[b]) begin
        r_rsp_mem[b][r_rsp_wr[b]] <= bank_rdata_i[b*DataWidth +: DataWidth];
      end
    end
  end

endmodule

// File: tb/tb_flash_phy_rd_sched.sv
// Bench for flash_phy_rd_sched: directed vector table, hand-written corner sequences,
// then random traffic against a request-order scoreboard model.
module tb_flash_phy_rd_sched;

  localparam int unsigned NB   = 3;
  localparam int unsigned OPB  = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 6;
  localparam int unsigned IW   = 4;
  localparam int unsigned SEQD = NB * OPB;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            host_req_i;
  logic [AW-1:0]   host_addr_i;
  logic            host_req_rdy_o;
  logic            host_req_done_o;
  logic [DW-1:0]   host_rdata_o;
  logic            host_rerr_o;
  logic [NB-1:0]   bank_req_o;
  logic [IW-1:0]   bank_addr_o;
  logic [NB-1:0]   bank_rdy_i;
  logic [NB-1:0]   bank_done_i;
  logic [NB*DW-1:0] bank_rdata_i;
  logic            idle_o;
  logic            proto_err_o;

  int n_vec = 0;
  int n_err = 0;

  flash_phy_rd_sched #(
    .NumBanks(NB), .PagesPerBank(4), .WordsPerPage(4), .DataWidth(DW), .OutPerBank(OPB)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_req_rdy_o(host_req_rdy_o),
    .host_req_done_o(host_req_done_o), .host_rdata_o(host_rdata_o), .host_rerr_o(host_rerr_o),
    .bank_req_o(bank_req_o), .bank_addr_o(bank_addr_o), .bank_rdy_i(bank_rdy_i),
    .bank_done_i(bank_done_i), .bank_rdata_i(bank_rdata_i),
    .idle_o(idle_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int req; int addr; int bdone; logic [DW-1:0] data;
    int rdy; int breq; int done; logic [DW-1:0] rdata; int rerr; int idle;
  } vec_t;
  vec_t tbl[$];

  typedef struct { logic err; int bank; logic vld; logic [DW-1:0] data; } req_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int rdy, input int breq, input int done,
                         input logic [31:0] rdata, input int rerr, input int idle);
    chk({tag, "_rdy"},   32'(host_req_rdy_o),  32'(rdy));
    chk({tag, "_breq"},  32'(bank_req_o),      32'(breq));
    chk({tag, "_done"},  32'(host_req_done_o), 32'(done));
    chk({tag, "_rdata"}, host_rdata_o,         rdata);
    chk({tag, "_rerr"},  32'(host_rerr_o),     32'(rerr));
    chk({tag, "_idle"},  32'(idle_o),          32'(idle));
  endtask

  function automatic logic [NB*DW-1:0] mkbus(input int dn, input logic [DW-1:0] d);
    logic [NB*DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = dn[b] ? d : (32'hBAD0_0000 | 32'(b));
    return r;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic cyc(input int req, input int addr, input int brdy, input int bdone,
                     input logic [NB*DW-1:0] bus);
    @(negedge clk_i);
    host_req_i   = req[0];
    host_addr_i  = AW'(addr);
    bank_rdy_i   = NB'(brdy);
    bank_done_i  = NB'(bdone);
    bank_rdata_i = bus;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; host_req_i = 1'b0; host_addr_i = '0;
    bank_rdy_i = '1; bank_done_i = '0; bank_rdata_i = '0;
    #1;
    chk("rst_idle",  32'(idle_o),          32'd1);
    chk("rst_done",  32'(host_req_done_o), 32'd0);
    chk("rst_rdata", host_rdata_o,         32'd0);
    chk("rst_rerr",  32'(host_rerr_o),     32'd0);
    chk("rst_perr",  32'(proto_err_o),     32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic vec_t mk(input int req, input int addr, input int bdone, input logic [DW-1:0] data,
                              input int rdy, input int breq, input int done, input logic [DW-1:0] rdata,
                              input int rerr, input int idle);
    vec_t v;
    v.req = req; v.addr = addr; v.bdone = bdone; v.data = data;
    v.rdy = rdy; v.breq = breq; v.done = done; v.rdata = rdata; v.rerr = rerr; v.idle = idle;
    return v;
  endfunction

  // Single read, bad bank behind a good read, lone bad bank, reorder
  task automatic build_table();
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 1));
    tbl.push_back(mk(1, 'h15, 0, 0,            1, 2, 0, 0,            0, 1));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 2, 32'hDEADBEEF, 1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 1));
    tbl.push_back(mk(1, 'h00, 0, 0,            1, 1, 0, 0,            0, 1));
    tbl.push_back(mk(1, 'h30, 0, 0,            1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 1, 32'h22,       1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 1, 32'h22,       0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 1, 0,            1, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 1));
    tbl.push_back(mk(1, 'h3F, 0, 0,            1, 0, 0, 0,            0, 1));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 1, 0,            1, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 1));
    tbl.push_back(mk(1, 'h01, 0, 0,            1, 1, 0, 0,            0, 1));
    tbl.push_back(mk(1, 'h12, 0, 0,            1, 2, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 2, 32'h11,       1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 1, 32'h22,       1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 1, 32'h22,       0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 1, 32'h11,       0, 0));
    tbl.push_back(mk(0, 'h00, 0, 0,            1, 0, 0, 0,            0, 1));
  endtask

  // Scoreboard: one entry per accepted request in issue order; a bank response
  // fills the oldest unfilled entry of that bank; the head retires once filled or bad
  task automatic run_random(input int ncyc);
    req_t m_q[$];
    req_t t;
    logic m_perr;
    m_perr = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      int pend[NB];
      int cred[NB];
      int req, addr, brdy, bdone, bank, good, e_rdy, issue, e_breq, e_done, e_rerr;
      logic [DW-1:0] e_rdata;
      logic [NB*DW-1:0] bus;
      string tg;
      for (int b = 0; b < NB; b++) begin pend[b] = 0; cred[b] = 0; end
      foreach (m_q[i]) begin
        if (!m_q[i].err) begin
          cred[m_q[i].bank]++;
          if (!m_q[i].vld) pend[m_q[i].bank]++;
        end
      end
      req   = ($urandom_range(0, 9) < 6) ? 1 : 0;
      addr  = int'($urandom_range(0, 63));
      brdy  = ($urandom_range(0, 3) != 0) ? 7 : int'($urandom_range(0, 7));
      bdone = 0;
      for (int b = 0; b < NB; b++) begin
        if (pend[b] > 0 ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 299) == 0))
          bdone = bdone | (1 << b);
        bus[b*DW +: DW] = $urandom();
      end
      bank = addr >> IW;
      good = (bank < int'(NB)) ? 1 : 0;
      if (m_q.size() >= int'(SEQD)) e_rdy = 0;
      else if (good == 0) e_rdy = 1;
      else e_rdy = (((brdy >> bank) & 1) == 1 && cred[bank] < int'(OPB)) ? 1 : 0;
      issue  = req & e_rdy;
      e_breq = (issue == 1 && good == 1) ? (1 << bank) : 0;
      e_done = 0; e_rerr = 0; e_rdata = '0;
      if (m_q.size() > 0) begin
        if (m_q[0].err) begin e_done = 1; e_rerr = 1; end
        else if (m_q[0].vld) begin e_done = 1; e_rdata = m_q[0].data; end
      end
      cyc(req, addr, brdy, bdone, bus);
      tg = $sformatf("rnd%0d", c);
      chk_out(tg, e_rdy, e_breq, e_done, e_rdata, e_rerr, (m_q.size() == 0) ? 1 : 0);
      chk({tg, "_perr"},  32'(proto_err_o), 32'(m_perr));
      chk({tg, "_baddr"}, 32'(bank_addr_o), 32'(addr & 15));
      if (e_done == 1) void'(m_q.pop_front());
      for (int b = 0; b < NB; b++) begin
        if (bdone[b]) begin
          if (pend[b] == 0) m_perr = 1'b1;
          else begin
            for (int j = 0; j < m_q.size(); j++) begin
              if (!m_q[j].err && m_q[j].bank == b && !m_q[j].vld) begin
                t = m_q[j]; t.vld = 1'b1; t.data = bus[b*DW +: DW]; m_q[j] = t;
                break;
              end
            end
          end
        end
      end
      if (issue == 1) begin
        t.err = (good == 0); t.bank = (good == 1) ? bank : 0; t.vld = 1'b0; t.data = '0;
        m_q.push_back(t);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; host_req_i = 1'b0; host_addr_i = '0;
    bank_rdy_i = '1; bank_done_i = '0; bank_rdata_i = '0;
    build_table();
    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].addr, 7, tbl[i].bdone, mkbus(tbl[i].bdone, tbl[i].data));
      chk_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].breq, tbl[i].done,
              tbl[i].rdata, tbl[i].rerr, tbl[i].idle);
      chk($sformatf("row%0d_perr", i),  32'(proto_err_o), 32'd0);
      chk($sformatf("row%0d_baddr", i), 32'(bank_addr_o), 32'(tbl[i].addr & 15));
    end

    // Credit limit on bank 0: third request stalls until a completion frees a credit
    cyc(1, 'h00, 7, 0, '0);                 chk_out("cl1", 1, 1, 0, 0, 0, 1);
    cyc(1, 'h00, 7, 0, '0);                 chk_out("cl2", 1, 1, 0, 0, 0, 0);
    cyc(1, 'h00, 7, 0, '0);                 chk_out("cl3", 0, 0, 0, 0, 0, 0);
    cyc(1, 'h00, 7, 1, mkbus(1, 32'hA1));   chk_out("cl4", 0, 0, 0, 0, 0, 0);
    cyc(1, 'h00, 7, 0, '0);                 chk_out("cl5", 0, 0, 1, 32'hA1, 0, 0);
    cyc(1, 'h00, 7, 0, '0);                 chk_out("cl6", 1, 1, 0, 0, 0, 0);
    cyc(0, 'h00, 7, 1, mkbus(1, 32'hA2));   chk_out("cl7", 0, 0, 0, 0, 0, 0);
    cyc(0, 'h00, 7, 1, mkbus(1, 32'hA3));   chk_out("cl8", 0, 0, 1, 32'hA2, 0, 0);
    cyc(0, 'h00, 7, 0, '0);                 chk_out("cl9", 1, 0, 1, 32'hA3, 0, 0);
    cyc(0, 'h00, 7, 0, '0);                 chk_out("cl10", 1, 0, 0, 0, 0, 1);

    // Sequence full: a pop in the same cycle does not free a slot for a new request
    for (int i = 0; i < 6; i++) begin
      cyc(1, (i / 2) << IW, 7, 0, '0);
      chk_out($sformatf("sf%0d", i), 1, 1 << (i / 2), 0, 0, 0, (i == 0) ? 1 : 0);
    end
    cyc(1, 'h30, 7, 1, mkbus(1, 32'hB0));   chk_out("sf6", 0, 0, 0, 0, 0, 0);
    cyc(1, 'h30, 7, 0, '0);                 chk_out("sf7", 0, 0, 1, 32'hB0, 0, 0);
    cyc(1, 'h30, 7, 0, '0);                 chk_out("sf8", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      int bk;
      bk = (i + 1) / 2;
      cyc(0, 'h30, 7, 1 << bk, mkbus(1 << bk, 32'hC0 + 32'(i)));
      chk_out($sformatf("sd%0d", i), (i >= 2) ? 1 : 0, 0, (i > 0) ? 1 : 0,
              (i > 0) ? 32'hC0 + 32'(i - 1) : 32'h0, 0, 0);
    end
    cyc(0, 'h30, 7, 0, '0);                 chk_out("sd5", 1, 0, 1, 32'hC4, 0, 0);
    cyc(0, 'h30, 7, 0, '0);                 chk_out("sd6", 1, 0, 1, 0, 1, 0);
    cyc(0, 'h30, 7, 0, '0);                 chk_out("sd7", 1, 0, 0, 0, 0, 1);

    // Reset with a read in flight; the late bank response is a straggler
    cyc(1, 'h00, 7, 0, '0);                 chk_out("rm0", 1, 1, 0, 0, 0, 1);
    do_reset();
    cyc(0, 'h00, 7, 1, mkbus(1, 32'h5A));   chk_out("rm1", 1, 0, 0, 0, 0, 1);
    chk("rm1_perr", 32'(proto_err_o), 32'd0);
    for (int i = 2; i < 5; i++) begin
      cyc(0, 'h00, 7, 0, '0);
      chk_out($sformatf("rm%0d", i), 1, 0, 0, 0, 0, 1);
      chk($sformatf("rm%0d_perr", i), 32'(proto_err_o), 32'd1);
    end

    do_reset();
    run_random(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
